// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks producers in EX..WB, stalls load-use, flushes
// taken branches and emits per-operand forward selects aligned to EX.
//
// Parameters: ADDR_W (register address width), NUM_RD (source operands),
//   DEPTH (tracked stages after ID, 1=EX), LOAD_DIST (nearest stage whose
//   load data can be forwarded), SELW (derived forward-code width).
// Ports: clk, rst (async, active-high); ID-side inputs id_valid, id_rs,
//   id_rs_used, id_rd, id_regwrite, id_load, branch_taken; outputs stall,
//   flush, issue, ex_valid and fwd_sel (code k: take the stage k+1 output,
//   code 0: register-file value).
// Optional HAZ_PERF_CNT_EN adds saturating 16-bit stall_cnt / flush_cnt.
module hazard_scoreboard #(
    parameter  int ADDR_W    = 5,
    parameter  int NUM_RD    = 2,
    parameter  int DEPTH     = 3,
    parameter  int LOAD_DIST = 2,
    localparam int SELW      = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_RD*ADDR_W-1:0] id_rs,
    input  logic [NUM_RD-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]        id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_load,
    input  logic                     branch_taken,
    output logic                     stall,
    output logic                     flush,
    output logic                     issue,
    output logic                     ex_valid,
    output logic [NUM_RD*SELW-1:0]   fwd_sel
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              regwrite;
        logic              load;
    } entry_t;

    entry_t st [1:DEPTH];

    logic [NUM_RD-1:0][SELW-1:0] code;
    logic [NUM_RD-1:0]           ld_near;

    // Scan from the oldest forwardable stage down to EX so that the last
    // hit, i.e. the youngest producer, decides the code and load status.
    // Stage DEPTH is skipped: the register file writes before it is read.
    always_comb begin
        code    = '0;
        ld_near = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (id_rs_used[j] && st[k].valid && st[k].regwrite &&
                    st[k].rd == id_rs[j*ADDR_W +: ADDR_W] &&
                    id_rs[j*ADDR_W +: ADDR_W] != '0) begin
                    code[j]    = SELW'(k);
                    ld_near[j] = st[k].load && (k < LOAD_DIST);
                end
            end
        end
    end

    // Reset masks the combinational controls so nothing leaks while held.
    assign stall    = ~rst & id_valid & (|ld_near);
    assign issue    = ~rst & id_valid & ~stall;
    assign flush    = ~rst & branch_taken & ~stall;
    assign ex_valid = st[1].valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                st[k] <= '0;
            end
            fwd_sel <= '0;
        end else begin
            if (issue) begin
                st[1] <= '{valid: 1'b1, rd: id_rd,
                           regwrite: id_regwrite, load: id_load};
            end else begin
                st[1] <= '0;
            end
            for (int k = 2; k <= DEPTH; k++) begin
                st[k] <= st[k-1];
            end
            fwd_sel <= issue ? code : '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard (default parameters).
// Rows drive ID inputs and check controls plus EX-aligned outputs.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_load;
    logic        branch_taken;
    logic        stall;
    logic        flush;
    logic        issue;
    logic        ex_valid;
    logic [3:0]  fwd_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_load      (id_load),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .issue        (issue),
        .ex_valid     (ex_valid),
        .fwd_sel      (fwd_sel)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       br;
        logic       es;
        logic       ef;
        logic       ei;
        logic       ev;
        logic [1:0] f0;
        logic [1:0] f1;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
        input logic [1:0] used, input logic [4:0] rd, input logic rw,
        input logic ld, input logic br, input logic es, input logic ef,
        input logic ei, input logic ev, input logic [1:0] f0,
        input logic [1:0] f1);
        vec_t r;
        r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used;
        r.rd = rd; r.rw = rw; r.ld = ld; r.br = br;
        r.es = es; r.ef = ef; r.ei = ei; r.ev = ev;
        r.f0 = f0; r.f1 = f1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs0,
                         input logic [4:0] rs1, input logic [1:0] used,
                         input logic [4:0] rd, input logic rw,
                         input logic ld, input logic br);
        id_valid     = v;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        id_rd        = rd;
        id_regwrite  = rw;
        id_load      = ld;
        branch_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           v rs0 rs1 use  rd rw ld br  st fl is ev f0 f1
        vecs[0]  = mk(1, 1,  2, 2'b11, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 5,  0, 2'b11, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[2]  = mk(1, 7,  5, 2'b11, 8, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        vecs[3]  = mk(1, 5,  6, 2'b11, 9, 1, 0, 0, 0, 0, 1, 1, 0, 2);
        vecs[4]  = mk(1, 1,  2, 2'b00, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2);
        vecs[5]  = mk(1, 0,  9, 2'b01, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[6]  = mk(1, 1,  2, 2'b11, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[7]  = mk(1, 5,  5, 2'b11, 10, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        vecs[8]  = mk(1, 10, 0, 2'b01, 7, 1, 1, 0, 0, 0, 1, 1, 1, 1);
        vecs[9]  = mk(1, 7,  5, 2'b11, 11, 1, 0, 1, 1, 0, 0, 1, 0, 0);
        vecs[10] = mk(1, 7,  5, 2'b11, 11, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        vecs[11] = mk(0, 11, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        vecs[12] = mk(0, 0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with hazardous-looking inputs: all controls masked.
        rst = 1'b1;
        drive(1, 7, 5, 2'b11, 5, 1, 1, 1);
        tick();
        chk("rst stall", stall, 1'b0);
        chk("rst flush", flush, 1'b0);
        chk("rst issue", issue, 1'b0);
        chk("rst ex_valid", ex_valid, 1'b0);
        chk("rst fwd_sel", fwd_sel, 4'h0);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rs0, vecs[i].rs1, vecs[i].used,
                  vecs[i].rd, vecs[i].rw, vecs[i].ld, vecs[i].br);
            #1;
            chk($sformatf("row%0d stall", i), stall, vecs[i].es);
            chk($sformatf("row%0d flush", i), flush, vecs[i].ef);
            chk($sformatf("row%0d issue", i), issue, vecs[i].ei);
            chk($sformatf("row%0d ex_valid", i), ex_valid, vecs[i].ev);
            chk($sformatf("row%0d fwd_sel", i), fwd_sel,
                {vecs[i].f1, vecs[i].f0});
            tick();
        end

`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 16'd1);
        chk("flush_cnt", flush_cnt, 16'd1);
`endif

        // Producer of x3, then load x7 forwarding x3, then a load-use.
        drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
        tick();
        drive(1, 3, 0, 2'b01, 7, 1, 1, 0);
        #1;
        chk("ld stall", stall, 1'b0);
        tick();
        drive(1, 7, 0, 2'b01, 12, 1, 0, 1);
        #1;
        chk("lu stall", stall, 1'b1);
        chk("lu flush", flush, 1'b0);
        chk("lu issue", issue, 1'b0);
        chk("lu ex_valid", ex_valid, 1'b1);
        chk("lu fwd_sel", fwd_sel, 4'h1);

        // Asynchronous reset mid-stall, between clock edges.
        #1;
        rst = 1'b1;
        #1;
        chk("arst stall", stall, 1'b0);
        chk("arst issue", issue, 1'b0);
        chk("arst flush", flush, 1'b0);
        chk("arst ex_valid", ex_valid, 1'b0);
        chk("arst fwd_sel", fwd_sel, 4'h0);
`ifdef HAZ_PERF_CNT_EN
        chk("arst stall_cnt", stall_cnt, 16'd0);
        chk("arst flush_cnt", flush_cnt, 16'd0);
`endif
        tick();
        rst = 1'b0;
        #1;
        chk("post stall", stall, 1'b0);
        chk("post issue", issue, 1'b1);
        chk("post flush", flush, 1'b1);
        tick();
        chk("post ex_valid", ex_valid, 1'b1);
        chk("post fwd_sel", fwd_sel, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameters: ADDR_W, 5, register address width.
REQ-002 NUM_RD, 2, number of source operands per instruction.
REQ-003 DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal 2..8.
REQ-004 LOAD_DIST, 2, minimum producer distance at which load data can be forwarded; legal 1..DEPTH-1.
REQ-005 SELW = max(1, clog2(DEPTH)), derived, width of one forward code.
REQ-006 The block SHALL have ports: clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 id_valid  in  1  valid instruction in ID.
REQ-009 id_rs  in  NUM_RD*ADDR_W  source addresses, operand j at bits [j*ADDR_W +: ADDR_W].
REQ-010 id_rs_used  in  NUM_RD  operand j is actually read.
REQ-011 id_rd, id_regwrite, id_load  in  ADDR_W/1/1  destination, writes register, is a load.
REQ-012 branch_taken  in  1  branch resolved taken in ID.
REQ-013 stall  out  1  hold PC and IF/ID register.
REQ-014 flush  out  1  clear IF/ID register.
REQ-015 issue  out  1  ID instruction enters EX on this edge.
REQ-016 ex_valid  out  1  EX holds a real (non-bubble) instruction.
REQ-017 fwd_sel  out  NUM_RD*SELW  registered forward code per operand, aligned to EX.

Function
REQ-018 The block SHALL keep a shift array stage[1..DEPTH] of {valid, rd, regwrite, load}; each edge stage[k+1] <= stage[k], and stage[1] <= ID fields if issue, else all-zero bubble.
REQ-019 issue SHALL equal id_valid & ~stall; ex_valid SHALL equal stage[1].valid.
REQ-020 Operand j SHALL match stage k when id_rs_used[j], stage[k].valid, stage[k].regwrite, stage[k].rd == rs_j and rs_j != 0.
REQ-021 Only k in 1..DEPTH-1 SHALL be considered; the register file writes before reading, so a stage-DEPTH producer needs no forwarding.
REQ-022 The lowest matching k (youngest producer) SHALL win; no match gives code 0.
REQ-023 stall SHALL be 1 when any operand's winning match is a load with k < LOAD_DIST and id_valid is 1; combinational, same cycle.
REQ-024 On issue, fwd_sel for operand j SHALL load its code k; on a non-issue edge it SHALL load 0.
REQ-025 fwd_sel code k SHALL mean: take EX operand from the output of stage k+1; code 0 means use the register-file value.
REQ-026 flush SHALL equal branch_taken & ~stall; stall has priority, and the branch re-resolves on the next cycle.
REQ-027 flush SHALL NOT suppress issue of the branch itself.
REQ-028 Stall, flush and forward decisions SHALL be independent per operand and SHALL hold for any NUM_RD >= 1.

Reset
REQ-029 While rst=1, all stage entries SHALL be 0 and fwd_sel=0, ex_valid=0.
REQ-030 While rst=1, stall, flush and issue SHALL be 0 regardless of inputs.
REQ-031 Reset asserted mid-stall SHALL discard all in-flight entries, and the first post-reset instruction SHALL see no hazards.

Configuration
REQ-032 With HAZ_PERF_CNT_EN defined, the block SHALL add ports stall_cnt and flush_cnt (out, 16 bits each).
REQ-033 stall_cnt SHALL increment on each stalled edge and flush_cnt on each flushed edge; both SHALL saturate at 16'hFFFF and reset to 0.
REQ-034 Without HAZ_PERF_CNT_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults: DEPTH=3, LOAD_DIST=2)
REQ-035 add x5 issues, then an instruction reading rs0=x5 -> no stall, fwd_sel[0]=1 in its EX cycle.
REQ-036 add x5, then one unrelated instruction, then a reader of x5 -> fwd_sel[0]=2; with two unrelated instructions between -> fwd_sel[0]=0.
REQ-037 Load x7 immediately followed by a reader of x7 -> stall=1 for exactly one cycle, one bubble (ex_valid=0), then fwd_sel[0]=2.
REQ-038 Writes to x0, or rs_used=0 with an address match -> no stall, fwd_sel=0; x5 written at k=1 and k=2 -> code 1 (youngest wins).
REQ-039 branch_taken during a load-use stall -> flush=0 that cycle; flush=1 the next cycle; with HAZ_PERF_CNT_EN, stall_cnt=1 and flush_cnt=1.
REQ-040 rst asserted while stall=1 -> stall, fwd_sel and ex_valid all 0 immediately (asynchronous), with no residual hazard after release.
